// File: rtl/vx_decode_ibuf.sv
// Per-warp decode-to-issue instruction buffer with a stall-stable
// round-robin arbiter, one-hot pop credits and per-warp flush.
module vx_decode_ibuf #(
    parameter int NUM_WARPS  = 4,
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int WID_WIDTH  = $clog2(NUM_WARPS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [WID_WIDTH-1:0]  in_wid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [WID_WIDTH-1:0]  out_wid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    input  logic                  flush_valid,
    input  logic [WID_WIDTH-1:0]  flush_wid,
    output logic [NUM_WARPS-1:0]  ibuf_pop,
    output logic [NUM_WARPS-1:0]  full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = WID_WIDTH + 1;

    typedef enum logic {
        ARB,
        HOLD
    } arb_state_e;

    logic [PW-1:0]         rd_ptr_q [NUM_WARPS];
    logic [PW-1:0]         rd_ptr_d [NUM_WARPS];
    logic [PW-1:0]         wr_ptr_q [NUM_WARPS];
    logic [PW-1:0]         wr_ptr_d [NUM_WARPS];
    logic [CW-1:0]         count_q  [NUM_WARPS];
    logic [CW-1:0]         count_d  [NUM_WARPS];
    logic [NUM_WARPS-1:0]  full_q;
    logic [NUM_WARPS-1:0]  full_d;
    logic [WID_WIDTH-1:0]  rr_q;
    logic [WID_WIDTH-1:0]  rr_d;
    logic [WID_WIDTH-1:0]  hold_wid_q;
    logic [WID_WIDTH-1:0]  hold_wid_d;
    arb_state_e            state_q;
    arb_state_e            state_d;

    logic [DATA_WIDTH-1:0] ram [NUM_WARPS][DEPTH];

    logic                  cand_valid;
    logic [WID_WIDTH-1:0]  cand_wid;
    logic [SW-1:0]         scan;
    logic                  pres_valid;
    logic [WID_WIDTH-1:0]  pres_wid;
    logic                  flush_hit;
    logic                  fire;
    logic [NUM_WARPS-1:0]  push_vec;
    logic [NUM_WARPS-1:0]  pop_vec;

    // First non-empty warp starting at the round-robin pointer.
    always_comb begin
        cand_valid = 1'b0;
        cand_wid   = '0;
        scan       = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            scan = {1'b0, rr_q} + SW'(i);
            if (scan >= SW'(NUM_WARPS)) begin
                scan = scan - SW'(NUM_WARPS);
            end
            if (!cand_valid && count_q[scan[WID_WIDTH-1:0]] != '0) begin
                cand_valid = 1'b1;
                cand_wid   = scan[WID_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        if (state_q == HOLD) begin
            pres_wid   = hold_wid_q;
            pres_valid = count_q[hold_wid_q] != '0;
        end else begin
            pres_wid   = cand_wid;
            pres_valid = cand_valid;
        end
        flush_hit = flush_valid && (flush_wid == pres_wid);
        out_valid = pres_valid && !flush_hit;
        out_wid   = pres_wid;
        out_data  = ram[pres_wid][rd_ptr_q[pres_wid]];
        fire      = out_valid && out_ready;
        in_ready  = !full_q[in_wid] && !(flush_valid && flush_wid == in_wid);
    end

    always_comb begin
        push_vec = '0;
        pop_vec  = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            push_vec[w] = in_valid && in_ready && (in_wid == WID_WIDTH'(w));
            pop_vec[w]  = fire && (out_wid == WID_WIDTH'(w));
        end
        ibuf_pop = pop_vec;
        full     = full_q;
    end

    // A flushed warp cannot push (in_ready) nor pop (out_valid mask).
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        full_d   = full_q;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (flush_valid && flush_wid == WID_WIDTH'(w)) begin
                rd_ptr_d[w] = '0;
                wr_ptr_d[w] = '0;
                count_d[w]  = '0;
            end else begin
                rd_ptr_d[w] = rd_ptr_q[w] + PW'(pop_vec[w]);
                wr_ptr_d[w] = wr_ptr_q[w] + PW'(push_vec[w]);
                count_d[w]  = count_q[w] + CW'(push_vec[w])
                            - CW'(pop_vec[w]);
            end
            full_d[w] = count_d[w] == CW'(DEPTH);
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_wid_d = hold_wid_q;
        rr_d       = rr_q;
        if (fire) begin
            if (out_wid == WID_WIDTH'(NUM_WARPS - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = out_wid + 1'b1;
            end
        end
        case (state_q)
            ARB: begin
                if (out_valid && !out_ready) begin
                    state_d    = HOLD;
                    hold_wid_d = pres_wid;
                end
            end
            HOLD: begin
                if (fire || (flush_valid && flush_wid == hold_wid_q)) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                rd_ptr_q[w] <= '0;
                wr_ptr_q[w] <= '0;
                count_q[w]  <= '0;
            end
            full_q     <= '0;
            rr_q       <= '0;
            hold_wid_q <= '0;
            state_q    <= ARB;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            rr_q       <= rr_d;
            hold_wid_q <= hold_wid_d;
            state_q    <= state_d;
        end
    end

    // Payload storage carries no reset; validity lives in the counts.
    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (push_vec[w]) begin
                ram[w][wr_ptr_q[w]] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_vx_decode_ibuf.sv
// Directed bench for vx_decode_ibuf: table of per-cycle vectors
// plus a hand-written reset-in-flight sequence.
module tb_vx_decode_ibuf;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [1:0]  in_wid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [1:0]  out_wid;
    logic [63:0] out_data;
    logic        out_ready;
    logic        flush_valid;
    logic [1:0]  flush_wid;
    logic [3:0]  ibuf_pop;
    logic [3:0]  full;

    vx_decode_ibuf dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_wid      (in_wid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_wid     (out_wid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .flush_valid (flush_valid),
        .flush_wid   (flush_wid),
        .ibuf_pop    (ibuf_pop),
        .full        (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [1:0]  iw;
        logic [63:0] id;
        logic        ordy;
        logic        fv;
        logic [1:0]  fw;
        logic        ev;
        logic [1:0]  ew;
        logic [63:0] ed;
        logic [3:0]  epop;
        logic [3:0]  efull;
        logic        eir;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    task automatic chk(input string nm, input int row,
                       input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h",
                     nm, row, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [1:0] iw,
                       input logic [63:0] id, input logic ordy,
                       input logic fv, input logic [1:0] fw,
                       input logic ev, input logic [1:0] ew,
                       input logic [63:0] ed, input logic [3:0] epop,
                       input logic [3:0] efull, input logic eir);
        vec_t v;
        v.iv = iv; v.iw = iw; v.id = id; v.ordy = ordy;
        v.fv = fv; v.fw = fw; v.ev = ev; v.ew = ew; v.ed = ed;
        v.epop = epop; v.efull = efull; v.eir = eir;
        vecs.push_back(v);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Single entry: push w2 A5, shown next cycle, popped, then empty.
        add(1, 2, 'hA5, 1, 0, 0, 0, 0, 0,     4'b0000, 4'b0000, 1);
        add(0, 0, 0,    1, 0, 0, 1, 2, 'hA5,  4'b0100, 4'b0000, 1);
        add(0, 0, 0,    1, 0, 0, 0, 0, 0,     4'b0000, 4'b0000, 1);
        // Fill warp 0 under stall; head held at 0x10.
        add(1, 0, 'h10, 0, 0, 0, 0, 0, 0,     4'b0000, 4'b0000, 1);
        add(1, 0, 'h11, 0, 0, 0, 1, 0, 'h10,  4'b0000, 4'b0000, 1);
        add(1, 0, 'h12, 0, 0, 0, 1, 0, 'h10,  4'b0000, 4'b0000, 1);
        add(1, 0, 'h13, 0, 0, 0, 1, 0, 'h10,  4'b0000, 4'b0000, 1);
        add(1, 0, 'h99, 0, 0, 0, 1, 0, 'h10,  4'b0000, 4'b0001, 0);
        add(0, 1, 0,    0, 0, 0, 1, 0, 'h10,  4'b0000, 4'b0001, 1);
        // Drain in order; full and in_ready recover one cycle after pop.
        add(0, 0, 0,    1, 0, 0, 1, 0, 'h10,  4'b0001, 4'b0001, 0);
        add(0, 0, 0,    1, 0, 0, 1, 0, 'h11,  4'b0001, 4'b0000, 1);
        add(0, 0, 0,    1, 0, 0, 1, 0, 'h12,  4'b0001, 4'b0000, 1);
        add(0, 0, 0,    1, 0, 0, 1, 0, 'h13,  4'b0001, 4'b0000, 1);
        add(0, 0, 0,    1, 0, 0, 0, 0, 0,     4'b0000, 4'b0000, 1);
        // Streaming push+pop across the pointer wrap.
        for (int i = 0; i <= 10; i++) begin
            add(i < 10, 0, 64'h20 + 64'(i), 1, 0, 0,
                i > 0, 0, 64'h1F + 64'(i),
                (i > 0) ? 4'b0001 : 4'b0000, 4'b0000, 1);
        end
        add(0, 0, 0,    1, 0, 0, 0, 0, 0,     4'b0000, 4'b0000, 1);
        // DEPTH-1 entries, then push and pop together: full stays 0.
        add(1, 0, 'h30, 0, 0, 0, 0, 0, 0,     4'b0000, 4'b0000, 1);
        add(1, 0, 'h31, 0, 0, 0, 1, 0, 'h30,  4'b0000, 4'b0000, 1);
        add(1, 0, 'h32, 0, 0, 0, 1, 0, 'h30,  4'b0000, 4'b0000, 1);
        add(1, 0, 'h33, 1, 0, 0, 1, 0, 'h30,  4'b0001, 4'b0000, 1);
        add(0, 0, 0,    1, 0, 0, 1, 0, 'h31,  4'b0001, 4'b0000, 1);
        add(0, 0, 0,    1, 0, 0, 1, 0, 'h32,  4'b0001, 4'b0000, 1);
        add(0, 0, 0,    1, 0, 0, 1, 0, 'h33,  4'b0001, 4'b0000, 1);
        add(0, 0, 0,    1, 0, 0, 0, 0, 0,     4'b0000, 4'b0000, 1);
        // Round-robin over warps 0, 1, 3 with two entries each.
        add(1, 0, 'h40, 0, 0, 0, 0, 0, 0,     4'b0000, 4'b0000, 1);
        add(1, 0, 'h41, 0, 0, 0, 1, 0, 'h40,  4'b0000, 4'b0000, 1);
        add(1, 1, 'h50, 0, 0, 0, 1, 0, 'h40,  4'b0000, 4'b0000, 1);
        add(1, 1, 'h51, 0, 0, 0, 1, 0, 'h40,  4'b0000, 4'b0000, 1);
        add(1, 3, 'h60, 0, 0, 0, 1, 0, 'h40,  4'b0000, 4'b0000, 1);
        add(1, 3, 'h61, 0, 0, 0, 1, 0, 'h40,  4'b0000, 4'b0000, 1);
        add(0, 0, 0,    1, 0, 0, 1, 0, 'h40,  4'b0001, 4'b0000, 1);
        add(0, 0, 0,    1, 0, 0, 1, 1, 'h50,  4'b0010, 4'b0000, 1);
        add(0, 0, 0,    1, 0, 0, 1, 3, 'h60,  4'b1000, 4'b0000, 1);
        add(0, 0, 0,    1, 0, 0, 1, 0, 'h41,  4'b0001, 4'b0000, 1);
        add(0, 0, 0,    1, 0, 0, 1, 1, 'h51,  4'b0010, 4'b0000, 1);
        add(0, 0, 0,    1, 0, 0, 1, 3, 'h61,  4'b1000, 4'b0000, 1);
        add(0, 0, 0,    1, 0, 0, 0, 0, 0,     4'b0000, 4'b0000, 1);
        // Hold stability: warp 2 held while warp 0 arrives.
        add(1, 2, 'h70, 0, 0, 0, 0, 0, 0,     4'b0000, 4'b0000, 1);
        add(0, 0, 0,    0, 0, 0, 1, 2, 'h70,  4'b0000, 4'b0000, 1);
        add(1, 0, 'h80, 0, 0, 0, 1, 2, 'h70,  4'b0000, 4'b0000, 1);
        add(0, 0, 0,    0, 0, 0, 1, 2, 'h70,  4'b0000, 4'b0000, 1);
        add(0, 0, 0,    1, 0, 0, 1, 2, 'h70,  4'b0100, 4'b0000, 1);
        add(0, 0, 0,    1, 0, 0, 1, 0, 'h80,  4'b0001, 4'b0000, 1);
        add(0, 0, 0,    1, 0, 0, 0, 0, 0,     4'b0000, 4'b0000, 1);
        // Flush of the held warp 1; warp 3 goes next.
        add(1, 1, 'h90, 0, 0, 0, 0, 0, 0,     4'b0000, 4'b0000, 1);
        add(1, 1, 'h91, 0, 0, 0, 1, 1, 'h90,  4'b0000, 4'b0000, 1);
        add(1, 1, 'h92, 0, 0, 0, 1, 1, 'h90,  4'b0000, 4'b0000, 1);
        add(1, 3, 'hA0, 0, 0, 0, 1, 1, 'h90,  4'b0000, 4'b0000, 1);
        add(0, 1, 0,    1, 1, 1, 0, 0, 0,     4'b0000, 4'b0000, 0);
        add(0, 0, 0,    1, 0, 0, 1, 3, 'hA0,  4'b1000, 4'b0000, 1);
        add(0, 0, 0,    1, 0, 0, 0, 0, 0,     4'b0000, 4'b0000, 1);
        // Flush of warp 2 while warp 0 fires.
        add(1, 0, 'hB0, 0, 0, 0, 0, 0, 0,     4'b0000, 4'b0000, 1);
        add(1, 2, 'hC0, 0, 0, 0, 1, 0, 'hB0,  4'b0000, 4'b0000, 1);
        add(0, 0, 0,    1, 1, 2, 1, 0, 'hB0,  4'b0001, 4'b0000, 1);
        add(0, 0, 0,    1, 0, 0, 0, 0, 0,     4'b0000, 4'b0000, 1);

        reset       = 1'b0;
        in_valid    = 1'b0;
        in_wid      = '0;
        in_data     = '0;
        out_ready   = 1'b0;
        flush_valid = 1'b0;
        flush_wid   = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_out_valid", -1, 64'(out_valid), 0);
        chk("reset_ibuf_pop",  -1, 64'(ibuf_pop),  0);
        chk("reset_full",      -1, 64'(full),      0);
        chk("reset_in_ready",  -1, 64'(in_ready),  1);
        @(negedge clk);
        reset = 1'b1;

        // Reset in flight: queue three entries on warp 1, then reset.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_wid   = 2'd1;
            in_data  = 64'h100 + 64'(i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre_reset_valid", -2, 64'(out_valid), 1);
        chk("pre_reset_wid",   -2, 64'(out_wid),   1);
        #1;
        reset = 1'b0;
        #1;
        chk("midreset_valid", -2, 64'(out_valid), 0);
        chk("midreset_full",  -2, 64'(full),      0);
        chk("midreset_pop",   -2, 64'(ibuf_pop),  0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("post_reset_valid", -3, 64'(out_valid), 0);
        end

        for (int r = 0; r < vecs.size(); r++) begin
            @(negedge clk);
            in_valid    = vecs[r].iv;
            in_wid      = vecs[r].iw;
            in_data     = vecs[r].id;
            out_ready   = vecs[r].ordy;
            flush_valid = vecs[r].fv;
            flush_wid   = vecs[r].fw;
            #1;
            chk("out_valid", r, 64'(out_valid), 64'(vecs[r].ev));
            chk("ibuf_pop",  r, 64'(ibuf_pop),  64'(vecs[r].epop));
            chk("full",      r, 64'(full),      64'(vecs[r].efull));
            chk("in_ready",  r, 64'(in_ready),  64'(vecs[r].eir));
            if (vecs[r].ev) begin
                chk("out_wid",  r, 64'(out_wid), 64'(vecs[r].ew));
                chk("out_data", r, out_data,     vecs[r].ed);
            end
        end

        @(negedge clk);
        in_valid    = 1'b0;
        flush_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
